// File: rtl/neosd_pkg.sv
// Shared types and constants for the neosd device-side CMD line logic.
package neosd_pkg;

  localparam int SHORT_FRAME_LEN = 48;
  localparam int LONG_FRAME_LEN  = 136;

  typedef enum logic [1:0] {
    RESP_NONE  = 2'b00,
    RESP_SHORT = 2'b01,
    RESP_LONG  = 2'b10
  } resp_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WAIT_RESP,
    ST_NCR_WAIT,
    ST_SEND
  } dev_cmd_state_t;

endpackage

// File: rtl/neosd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled cycle, MSB-first.
// With clr_i and en_i together the remainder restarts from zero and absorbs dat_i.
module neosd_crc7 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       dat_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_reg;
  logic [6:0] base;
  logic       fb;

  always_comb begin
    base = clr_i ? 7'd0 : crc_reg;
    fb   = dat_i ^ base[6];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_reg <= 7'd0;
    end else if (en_i) begin
      crc_reg <= {base[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    end else if (clr_i) begin
      crc_reg <= 7'd0;
    end
  end

  assign crc_o = crc_reg;

endmodule

// File: rtl/neosd_dev_cmd_fsm.sv
// Device-side SD CMD line engine: receives host command frames and sends short/long responses.
// Define NEOSD_DEV_CMD_CRC_CHECK_EN to also reject received frames whose CRC7 does not match.
module neosd_dev_cmd_fsm
  import neosd_pkg::*;
#(
  parameter int NCR = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clkstrb_i,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  output logic [5:0]   cmd_idx_o,
  output logic [31:0]  cmd_arg_o,
  output logic         cmd_valid_o,
  output logic         cmd_err_o,
  input  logic         resp_start_i,
  input  logic [1:0]   resp_mode_i,
  input  logic [5:0]   resp_idx_i,
  input  logic [127:0] resp_data_i,
  input  logic         resp_nocrc_i,
  output logic         busy_o,
  output logic         resp_done_o
);

`ifdef NEOSD_DEV_CMD_CRC_CHECK_EN
  localparam bit CRC_CHECK_EN = 1'b1;
`else
  localparam bit CRC_CHECK_EN = 1'b0;
`endif

  localparam int NCR_W = $clog2(NCR + 1);

  dev_cmd_state_t state_reg, state_next;
  logic [45:0]    rx_shreg_reg, rx_shreg_next;
  logic [5:0]     rx_cnt_reg, rx_cnt_next;
  logic [NCR_W-1:0] ncr_cnt_reg, ncr_cnt_next;
  logic [135:0]   tx_shreg_reg, tx_shreg_next;
  logic [7:0]     tx_cnt_reg, tx_cnt_next;
  logic           tx_long_reg, tx_long_next;
  logic           tx_crc_ins_reg, tx_crc_ins_next;
  logic [5:0]     cmd_idx_reg, cmd_idx_next;
  logic [31:0]    cmd_arg_reg, cmd_arg_next;
  logic           cmd_valid_reg, cmd_valid_next;
  logic           cmd_err_reg, cmd_err_next;
  logic           resp_done_reg, resp_done_next;

  logic           rx_crc_clr, rx_crc_en;
  logic           tx_crc_clr, tx_crc_en, tx_crc_din;
  logic [6:0]     rx_crc, tx_crc;
  logic [46:0]    rx_frame;
  logic           rx_frame_ok;
  logic [NCR_W-1:0] ncr_inc;
  logic [135:0]   tx_shift;
  logic [7:0]     tx_flen;

  neosd_crc7 u_rx_crc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (rx_crc_clr),
    .en_i  (rx_crc_en),
    .dat_i (sd_cmd_i),
    .crc_o (rx_crc)
  );

  neosd_crc7 u_tx_crc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (tx_crc_clr),
    .en_i  (tx_crc_en),
    .dat_i (tx_crc_din),
    .crc_o (tx_crc)
  );

  // Start bit (47) is never stored: it is always 0 and only feeds the CRC.
  assign rx_frame    = {rx_shreg_reg, sd_cmd_i};
  assign rx_frame_ok = rx_frame[46] & rx_frame[0] &
                       ((rx_crc == rx_frame[7:1]) | ~CRC_CHECK_EN);
  assign ncr_inc     = (ncr_cnt_reg >= NCR_W'(NCR)) ? ncr_cnt_reg : ncr_cnt_reg + NCR_W'(1);
  assign tx_flen     = tx_long_reg ? 8'(LONG_FRAME_LEN) : 8'(SHORT_FRAME_LEN);

  always_comb begin
    // Ones are shifted in behind the frame so the trailing idle bit comes for free.
    tx_shift = {tx_shreg_reg[134:0], 1'b1};
    if (tx_crc_ins_reg && tx_cnt_reg == 8'd40) begin
      tx_shift[135:129] = tx_crc;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rx_shreg_next   = rx_shreg_reg;
    rx_cnt_next     = rx_cnt_reg;
    ncr_cnt_next    = ncr_cnt_reg;
    tx_shreg_next   = tx_shreg_reg;
    tx_cnt_next     = tx_cnt_reg;
    tx_long_next    = tx_long_reg;
    tx_crc_ins_next = tx_crc_ins_reg;
    cmd_idx_next    = cmd_idx_reg;
    cmd_arg_next    = cmd_arg_reg;
    cmd_valid_next  = 1'b0;
    cmd_err_next    = 1'b0;
    resp_done_next  = 1'b0;
    rx_crc_clr      = 1'b0;
    rx_crc_en       = 1'b0;
    tx_crc_clr      = 1'b0;
    tx_crc_en       = 1'b0;
    tx_crc_din      = tx_shift[135];

    if (clkstrb_i) begin
      case (state_reg)
        ST_IDLE: begin
          if (!sd_cmd_i) begin
            state_next  = ST_RECV;
            rx_cnt_next = 6'd46;
            rx_crc_clr  = 1'b1;
            rx_crc_en   = 1'b1;
          end
        end
        ST_RECV: begin
          rx_shreg_next = {rx_shreg_reg[44:0], sd_cmd_i};
          rx_crc_en     = (rx_cnt_reg >= 6'd8);
          if (rx_cnt_reg == 6'd0) begin
            if (rx_frame_ok) begin
              cmd_idx_next   = rx_frame[45:40];
              cmd_arg_next   = rx_frame[39:8];
              cmd_valid_next = 1'b1;
              ncr_cnt_next   = '0;
              state_next     = ST_WAIT_RESP;
            end else begin
              cmd_err_next = 1'b1;
              state_next   = ST_IDLE;
            end
          end else begin
            rx_cnt_next = rx_cnt_reg - 6'd1;
          end
        end
        ST_WAIT_RESP: begin
          ncr_cnt_next = ncr_inc;
          if (!sd_cmd_i) begin
            // Host issued a new command instead of waiting: drop the response.
            state_next  = ST_RECV;
            rx_cnt_next = 6'd46;
            rx_crc_clr  = 1'b1;
            rx_crc_en   = 1'b1;
          end else if (resp_start_i) begin
            if (resp_mode_i == RESP_SHORT) begin
              tx_shreg_next   = {2'b00, resp_idx_i, resp_data_i[31:0], 7'h7F, 1'b1, {88{1'b1}}};
              tx_long_next    = 1'b0;
              tx_crc_ins_next = ~resp_nocrc_i;
              state_next      = ST_NCR_WAIT;
            end else if (resp_mode_i == RESP_LONG) begin
              tx_shreg_next   = {2'b00, 6'h3F, resp_data_i[127:1], 1'b1};
              tx_long_next    = 1'b1;
              tx_crc_ins_next = 1'b0;
              state_next      = ST_NCR_WAIT;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
        ST_NCR_WAIT: begin
          if (ncr_cnt_reg >= NCR_W'(NCR)) begin
            state_next  = ST_SEND;
            tx_cnt_next = 8'd1;
            tx_crc_clr  = 1'b1;
            tx_crc_en   = 1'b1;
            tx_crc_din  = tx_shreg_reg[135];
          end else begin
            ncr_cnt_next = ncr_inc;
          end
        end
        ST_SEND: begin
          if (tx_cnt_reg == tx_flen + 8'd1) begin
            state_next     = ST_IDLE;
            tx_cnt_next    = 8'd0;
            resp_done_next = 1'b1;
          end else begin
            tx_shreg_next = tx_shift;
            tx_cnt_next   = tx_cnt_reg + 8'd1;
            tx_crc_en     = (tx_cnt_reg < 8'd40);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      rx_shreg_reg   <= '0;
      rx_cnt_reg     <= '0;
      ncr_cnt_reg    <= '0;
      tx_shreg_reg   <= '0;
      tx_cnt_reg     <= '0;
      tx_long_reg    <= 1'b0;
      tx_crc_ins_reg <= 1'b0;
      cmd_idx_reg    <= '0;
      cmd_arg_reg    <= '0;
      cmd_valid_reg  <= 1'b0;
      cmd_err_reg    <= 1'b0;
      resp_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rx_shreg_reg   <= rx_shreg_next;
      rx_cnt_reg     <= rx_cnt_next;
      ncr_cnt_reg    <= ncr_cnt_next;
      tx_shreg_reg   <= tx_shreg_next;
      tx_cnt_reg     <= tx_cnt_next;
      tx_long_reg    <= tx_long_next;
      tx_crc_ins_reg <= tx_crc_ins_next;
      cmd_idx_reg    <= cmd_idx_next;
      cmd_arg_reg    <= cmd_arg_next;
      cmd_valid_reg  <= cmd_valid_next;
      cmd_err_reg    <= cmd_err_next;
      resp_done_reg  <= resp_done_next;
    end
  end

  assign sd_cmd_oe   = (state_reg == ST_SEND);
  assign sd_cmd_o    = (state_reg == ST_SEND) ? tx_shreg_reg[135] : 1'b1;
  assign busy_o      = (state_reg != ST_IDLE);
  assign cmd_idx_o   = cmd_idx_reg;
  assign cmd_arg_o   = cmd_arg_reg;
  assign cmd_valid_o = cmd_valid_reg;
  assign cmd_err_o   = cmd_err_reg;
  assign resp_done_o = resp_done_reg;

endmodule

// File: tb/tb_neosd_dev_cmd_fsm.sv
// Bench for neosd_dev_cmd_fsm: directed SD scenarios plus random command/response traffic.
`timescale 1ns/1ps
module tb_neosd_dev_cmd_fsm;

  localparam int NCR       = 3;
  localparam int MAX_TICKS = 400;

`ifdef NEOSD_DEV_CMD_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i, clkstrb_i, sd_cmd_i, resp_start_i, resp_nocrc_i;
  logic [1:0]   resp_mode_i;
  logic [5:0]   resp_idx_i;
  logic [127:0] resp_data_i;
  logic         sd_cmd_o, sd_cmd_oe, cmd_valid_o, cmd_err_o, busy_o, resp_done_o;
  logic [5:0]   cmd_idx_o;
  logic [31:0]  cmd_arg_o;

  int n_tests = 0, n_fail = 0;
  int valid_cnt = 0, err_cnt = 0, done_cnt = 0;
  logic smp_oe, smp_o;
  bit   oe_seen;
  bit   last_valid;
  logic [5:0]   exp_idx;
  logic [31:0]  exp_arg;
  logic [135:0] last_cap;

  neosd_dev_cmd_fsm #(.NCR(NCR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clkstrb_i(clkstrb_i),
    .sd_cmd_i(sd_cmd_i), .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe),
    .cmd_idx_o(cmd_idx_o), .cmd_arg_o(cmd_arg_o),
    .cmd_valid_o(cmd_valid_o), .cmd_err_o(cmd_err_o),
    .resp_start_i(resp_start_i), .resp_mode_i(resp_mode_i), .resp_idx_i(resp_idx_i),
    .resp_data_i(resp_data_i), .resp_nocrc_i(resp_nocrc_i),
    .busy_o(busy_o), .resp_done_o(resp_done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (cmd_valid_o) valid_cnt++;
    if (cmd_err_o)   err_cnt++;
    if (resp_done_o) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference CRC7 by polynomial long division of the 40 message bits.
  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
  endfunction

  // Expected response bits, right-aligned (48 or 136 significant bits).
  function automatic logic [135:0] resp_model(input logic [1:0] mode, input logic [5:0] idx,
                                              input logic [127:0] data, input bit nocrc);
    logic [39:0] head;
    logic [6:0]  c;
    if (mode == 2'b10) return {2'b00, 6'h3F, data[127:1], 1'b1};
    head = {2'b00, idx, data[31:0]};
    c    = nocrc ? 7'h7F : crc7_ref(head);
    return {88'd0, head, c, 1'b1};
  endfunction

  // One SD clock strobe after 0..2 idle clk cycles; line state sampled after the strobe edge.
  task automatic tick(input logic cmd_bit, input logic start);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) @(negedge clk_i);
    clkstrb_i    = 1'b1;
    sd_cmd_i     = cmd_bit;
    resp_start_i = start;
    @(negedge clk_i);
    clkstrb_i    = 1'b0;
    resp_start_i = 1'b0;
    smp_oe = sd_cmd_oe;
    smp_o  = sd_cmd_o;
    if (smp_oe) oe_seen = 1'b1;
    else check_eq("line_high_when_released", smp_o, 1'b1);
  endtask

  task automatic do_cmd(input logic [47:0] f);
    int v0, e0;
    bit ok;
    ok = f[46] && f[0] && (!CRC_EN || crc7_ref(f[47:8]) == f[7:1]);
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 47; i >= 0; i--) tick(f[i], 1'b0);
    sd_cmd_i = 1'b1;
    @(negedge clk_i);
    if (ok) begin
      exp_idx = f[45:40];
      exp_arg = f[39:8];
    end
    last_valid = ok;
    $display("[TB] cmd frame %h expect_valid=%0d", f, ok);
    check_eq("cmd_valid_pulses", 136'(valid_cnt - v0), 136'(ok));
    check_eq("cmd_err_pulses", 136'(err_cnt - e0), 136'(!ok));
    check_eq("cmd_idx", cmd_idx_o, exp_idx);
    check_eq("cmd_arg", cmd_arg_o, exp_arg);
    check_eq("busy_after_cmd", busy_o, ok);
  endtask

  task automatic do_resp(input logic [1:0] mode, input logic [5:0] idx, input logic [127:0] data,
                         input bit nocrc, input int pre_gap, input int rst_at);
    logic [135:0] exp_f, cap;
    int  len, ncap, k, first_k, d0;
    bit  finished, aborted, extra, expect_tx;
    expect_tx = last_valid && (mode == 2'b01 || mode == 2'b10);
    exp_f = resp_model(mode, idx, data, nocrc);
    len   = (mode == 2'b10) ? 136 : 48;
    resp_mode_i = mode; resp_idx_i = idx; resp_data_i = data; resp_nocrc_i = nocrc;
    d0 = done_cnt; oe_seen = 1'b0;
    cap = '0; ncap = 0; first_k = 0; finished = 1'b0; aborted = 1'b0; extra = 1'b0;
    repeat (pre_gap) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    k = pre_gap + 1;
    last_valid = 1'b0;
    if (!expect_tx) begin
      check_eq("idle_after_no_resp", busy_o, 1'b0);
      repeat (NCR + 4) tick(1'b1, 1'b0);
      check_eq("no_resp_driven", oe_seen, 1'b0);
      $display("[TB] resp mode=%0d not sent", mode);
    end else begin
      while (!finished && !aborted && k < MAX_TICKS) begin
        tick(1'b1, 1'b0);
        k++;
        if (smp_oe) begin
          if (ncap == 0) first_k = k;
          if (ncap < len) cap = {cap[134:0], smp_o};
          else extra = smp_o;
          ncap++;
          if (rst_at != 0 && ncap == rst_at) begin
            rst_i = 1'b1;
            #1;
            check_eq("rst_oe_low", sd_cmd_oe, 1'b0);
            check_eq("rst_line_high", sd_cmd_o, 1'b1);
            check_eq("rst_busy_low", busy_o, 1'b0);
            @(negedge clk_i);
            rst_i = 1'b0;
            exp_idx = '0;
            exp_arg = '0;
            check_eq("rst_cmd_idx", cmd_idx_o, exp_idx);
            check_eq("rst_cmd_arg", cmd_arg_o, exp_arg);
            check_eq("rst_no_done", 136'(done_cnt - d0), 136'(0));
            aborted = 1'b1;
          end
        end else if (ncap > 0) begin
          finished = 1'b1;
        end
      end
      $display("[TB] resp mode=%0d bits=%0d start_strobe=%0d", mode, ncap, first_k);
      if (!aborted) begin
        @(negedge clk_i);
        last_cap = cap;
        check_eq("resp_finished", finished, 1'b1);
        check_eq("ncr_gap_min", 136'(first_k >= NCR), 136'(1));
        check_eq("resp_bits", cap, exp_f);
        check_eq("resp_bit_count", 136'(ncap), 136'(len + 1));
        check_eq("resp_trailing_one", extra, 1'b1);
        check_eq("resp_done_pulses", 136'(done_cnt - d0), 136'(1));
        check_eq("idle_after_resp", busy_o, 1'b0);
      end
    end
  endtask

  initial begin
    logic [47:0]  f;
    logic [5:0]   ridx;
    logic [31:0]  rarg;
    int           kind, pos;
    rst_i = 1'b0; clkstrb_i = 1'b0; sd_cmd_i = 1'b1; resp_start_i = 1'b0;
    resp_mode_i = 2'b00; resp_idx_i = '0; resp_data_i = '0; resp_nocrc_i = 1'b0;
    exp_idx = '0; exp_arg = '0; last_valid = 1'b0; last_cap = '0; oe_seen = 1'b0;
    #2 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_eq("reset_oe", sd_cmd_oe, 1'b0);
    check_eq("reset_line", sd_cmd_o, 1'b1);
    check_eq("reset_busy", busy_o, 1'b0);
    check_eq("reset_valid", cmd_valid_o, 1'b0);
    check_eq("reset_err", cmd_err_o, 1'b0);
    check_eq("reset_done", resp_done_o, 1'b0);
    check_eq("reset_idx", cmd_idx_o, 6'd0);
    check_eq("reset_arg", cmd_arg_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    do_cmd(48'h400000000095);
    do_resp(2'b00, 6'd0, '0, 1'b0, 0, 0);

    do_cmd(48'h48000001AA87);
    do_resp(2'b01, 6'd8, 128'h1AA, 1'b0, 0, 0);
    check_eq("r7_literal", last_cap[47:0], 48'h08000001AA13);

    do_cmd(48'h48000001AA86);
    do_resp(2'b00, 6'd0, '0, 1'b0, 0, 0);

    do_cmd(48'h400000000095);
    do_resp(2'b10, 6'd0, '1, 1'b0, 0, 0);

    do_cmd(48'h48000001AA87);
    oe_seen = 1'b0;
    do_cmd(48'h400000000095);
    repeat (NCR + 4) tick(1'b1, 1'b0);
    check_eq("abort_no_oe", oe_seen, 1'b0);
    do_resp(2'b11, 6'd0, '0, 1'b0, 0, 0);

    do_cmd(48'h48000001AA87);
    do_resp(2'b10, 6'd0, {4{$urandom}}, 1'b0, 0, 20);
    do_cmd(48'h400000000095);
    do_resp(2'b00, 6'd0, '0, 1'b0, 0, 0);

    for (int t = 0; t < 20; t++) begin
      ridx = 6'($urandom);
      rarg = $urandom;
      f    = cmd_frame(ridx, rarg);
      kind = $urandom_range(0, 5);
      if (kind == 3) f[46] = 1'b0;
      if (kind == 4) f[0]  = 1'b0;
      if (kind == 5) begin
        pos    = 1 + $urandom_range(0, 6);
        f[pos] = ~f[pos];
      end
      do_cmd(f);
      do_resp(2'($urandom_range(0, 3)), 6'($urandom), {4{$urandom}},
              1'($urandom_range(0, 1)), $urandom_range(0, NCR + 1), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neosd_dev_cmd_fsm.md
NEOSD_DEV_CMD_FSM -- requirements
Module: neosd_dev_cmd_fsm

Interface
REQ-001 SHALL have parameter NCR, default 2, range 2..64: minimum SD clock strobes from command end bit to response start bit.
REQ-002 SHALL have port clk_i  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port clkstrb_i  in  1  one-cycle strobe; CMD line sampled and driven only on cycles where it is 1.
REQ-005 SHALL have ports sd_cmd_i (in, 1), sd_cmd_o (out, 1) and sd_cmd_oe (out, 1): CMD wire as seen from the card side.
REQ-006 SHALL have ports cmd_idx_o (out, 6), cmd_arg_o (out, 32), cmd_valid_o (out, 1) and cmd_err_o (out, 1): received command and its status pulses.
REQ-007 SHALL have ports resp_start_i (in, 1), resp_mode_i (in, 2), resp_idx_i (in, 6), resp_data_i (in, 128), resp_nocrc_i (in, 1): response request and content.
REQ-008 SHALL have ports busy_o (out, 1) and resp_done_o (out, 1).

Function
REQ-009 SHALL implement states IDLE, RECV, WAIT_RESP, NCR_WAIT, SEND; all transitions and counters advance only when clkstrb_i=1.
REQ-010 IDLE: sampled sd_cmd_i=0 SHALL be bit 47 (start bit); go to RECV with bit counter 46.
REQ-011 RECV SHALL shift sd_cmd_i MSB-first into a 48-bit register, decrementing the counter; after bit 0 it SHALL evaluate the frame.
REQ-012 The frame SHALL be valid iff bit 46=1 (transmission bit), bit 0=1 (end bit) and CRC7 (x^7+x^3+1, over bits 47..8) equals bits 7..1.
REQ-013 Valid frame: cmd_idx_o<=bits 45..40, cmd_arg_o<=bits 39..8, one clk_i cycle pulse on cmd_valid_o, go to WAIT_RESP, NCR counter<=0; outputs hold until the next valid frame.
REQ-014 Invalid frame: one-cycle pulse on cmd_err_o, cmd_idx_o/cmd_arg_o unchanged, go to IDLE.
REQ-015 WAIT_RESP/NCR_WAIT SHALL count strobes since the end bit, saturating at NCR.
REQ-016 WAIT_RESP on resp_start_i=1: mode NONE (00) SHALL go to IDLE; mode SHORT (01) or LONG (10) SHALL latch all resp_* inputs, then go to NCR_WAIT; mode 11 SHALL be treated as NONE.
REQ-017 NCR_WAIT SHALL enter SEND when count>=NCR, asserting sd_cmd_oe with the start bit on that strobe.
REQ-018 SHORT frame (48 bits) SHALL be: 0, 0, resp_idx, resp_data[31:0], CRC7 over the preceding 40 bits (1111111 if resp_nocrc=1), 1.
REQ-019 LONG frame (136 bits) SHALL be: 0, 0, 111111, resp_data[127:1], 1; no CRC is generated.
REQ-020 Each frame bit SHALL be held on sd_cmd_o for exactly one strobe period.
REQ-021 After the end bit, SEND SHALL drive 1 for one more strobe, then deassert sd_cmd_oe, pulse resp_done_o for one cycle and go to IDLE.
REQ-022 A sampled sd_cmd_i=0 in WAIT_RESP SHALL abort the pending response and start RECV with that bit as the start bit.
REQ-023 resp_start_i outside WAIT_RESP SHALL be ignored.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 sd_cmd_oe SHALL be 1 only in SEND; sd_cmd_o SHALL be 1 whenever sd_cmd_oe=0.

Reset
REQ-026 rst_i=1 SHALL immediately force state IDLE and sd_cmd_oe=0, sd_cmd_o=1, cmd_valid_o=0, cmd_err_o=0, resp_done_o=0, busy_o=0, cmd_idx_o=0, cmd_arg_o=0, all counters 0; this includes reset mid-SEND.

Configuration
REQ-027 With NEOSD_DEV_CMD_CRC_CHECK_EN defined, REQ-012 SHALL apply in full.
REQ-028 Without NEOSD_DEV_CMD_CRC_CHECK_EN, the received CRC SHALL be ignored; only the transmission bit and end bit are checked. TX CRC generation is unaffected.

Structure
REQ-029 Package neosd_pkg SHALL hold the RESP_NONE/RESP_SHORT/RESP_LONG enum (00/01/10), the device CMD state enum, and the frame-length constants 48 and 136.
REQ-030 Serial CRC7 SHALL be a sub-module neosd_crc7 (clear, enable, data bit, 7-bit remainder), instantiated once each for RX and TX.

Verification
REQ-031 Drive frame 0x400000000095 (CMD0) -> cmd_valid_o pulse, idx=0, arg=0x00000000, no cmd_err_o.
REQ-032 Drive frame 0x48000001AA87, then resp SHORT idx=8, data=0x1AA -> after >=NCR strobes sd_cmd_o emits 0x08000001AA13, then resp_done_o.
REQ-033 Drive 0x48000001AA86 (bad CRC) -> cmd_err_o pulse, no cmd_valid_o; without the macro -> cmd_valid_o pulse instead.
REQ-034 Request LONG with data=all-ones -> exactly 136 driven bits: 00, 111111, 127 ones, end bit 1; then oe falls after one extra bit.
REQ-035 In WAIT_RESP, drive a new CMD0 -> pending response dropped, CMD0 received, sd_cmd_oe never asserted.
REQ-036 Assert rst_i at bit 20 of SEND -> sd_cmd_oe=0 in the same cycle; next CMD0 is received normally.
